// File: rtl/sa_pe_ws.sv
// Weight-stationary systolic PE: registered act/psum forwarding, double-buffered
// weight chain, saturating MAC. Optional sticky saturation flag via SA_PE_SAT_FLAG_EN.

module sa_mac_simple #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 8
) (
    input  logic signed [MUL_DATAWIDTH-1:0] a_i,
    input  logic signed [MUL_DATAWIDTH-1:0] b_i,
    input  logic signed [ADD_DATAWIDTH-1:0] c_i,
`ifdef SA_PE_SAT_FLAG_EN
    output logic                            prod_sat_o,
    output logic                            sum_sat_o,
`endif
    output logic signed [ADD_DATAWIDTH-1:0] y_o
);
    localparam int M  = MUL_DATAWIDTH;
    localparam int A  = ADD_DATAWIDTH;
    localparam int PW = 2 * M;
    // Sum width covers the wider operand plus one carry bit.
    localparam int SW = ((M > A) ? M : A) + 1;

    localparam logic signed [PW-1:0] PMAX = PW'({1'b0, {(M-1){1'b1}}});
    localparam logic signed [PW-1:0] PMIN = PW'($signed({1'b1, {(M-1){1'b0}}}));
    localparam logic signed [SW-1:0] SMAX = SW'({1'b0, {(A-1){1'b1}}});
    localparam logic signed [SW-1:0] SMIN = SW'($signed({1'b1, {(A-1){1'b0}}}));

    logic signed [PW-1:0] prod;
    logic signed [M-1:0]  prod_s;
    logic signed [SW-1:0] sum;
    logic                 p_hi, p_lo, s_hi, s_lo;

    always_comb begin
        prod   = PW'(a_i) * PW'(b_i);
        p_hi   = prod > PMAX;
        p_lo   = prod < PMIN;
        prod_s = p_hi ? {1'b0, {(M-1){1'b1}}} :
                 p_lo ? {1'b1, {(M-1){1'b0}}} : prod[M-1:0];
        sum    = SW'(prod_s) + SW'(c_i);
        s_hi   = sum > SMAX;
        s_lo   = sum < SMIN;
        y_o    = s_hi ? {1'b0, {(A-1){1'b1}}} :
                 s_lo ? {1'b1, {(A-1){1'b0}}} : sum[A-1:0];
    end

`ifdef SA_PE_SAT_FLAG_EN
    assign prod_sat_o = p_hi | p_lo;
    assign sum_sat_o  = s_hi | s_lo;
`endif
endmodule

module sa_pe_ws #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_w_valid,
    input  logic signed [MUL_DATAWIDTH-1:0] i_weight,
    output logic                            o_w_valid,
    output logic signed [MUL_DATAWIDTH-1:0] o_weight,
    input  logic                            i_swap,
    output logic                            o_swap,
    input  logic                            i_act_valid,
    input  logic signed [MUL_DATAWIDTH-1:0] i_act,
    output logic                            o_act_valid,
    output logic signed [MUL_DATAWIDTH-1:0] o_act,
    input  logic                            i_psum_valid,
    input  logic signed [ADD_DATAWIDTH-1:0] i_psum,
`ifdef SA_PE_SAT_FLAG_EN
    input  logic                            i_sat_clr,
    output logic                            o_sat_sticky,
`endif
    output logic                            o_psum_valid,
    output logic signed [ADD_DATAWIDTH-1:0] o_psum
);
    logic signed [MUL_DATAWIDTH-1:0] shadow_q, active_q, weight_q, act_q;
    logic signed [ADD_DATAWIDTH-1:0] psum_q;
    logic                            loaded_q, w_valid_q, swap_q, act_valid_q, psum_valid_q;
    logic signed [MUL_DATAWIDTH-1:0] mac_w;
    logic signed [ADD_DATAWIDTH-1:0] mac_c, mac_y;

    // Compute always sees the pre-swap active weight; a swap lands next cycle.
    assign mac_w = loaded_q ? active_q : '0;
    assign mac_c = i_psum_valid ? i_psum : '0;

`ifdef SA_PE_SAT_FLAG_EN
    logic prod_sat, sum_sat, sticky_q;

    sa_mac_simple #(.MUL_DATAWIDTH(MUL_DATAWIDTH), .ADD_DATAWIDTH(ADD_DATAWIDTH)) u_mac (
        .a_i(i_act), .b_i(mac_w), .c_i(mac_c),
        .prod_sat_o(prod_sat), .sum_sat_o(sum_sat), .y_o(mac_y)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)                                     sticky_q <= 1'b0;
        else if (i_act_valid && (prod_sat || sum_sat)) sticky_q <= 1'b1;
        else if (i_sat_clr)                            sticky_q <= 1'b0;
    end

    assign o_sat_sticky = sticky_q;
`else
    sa_mac_simple #(.MUL_DATAWIDTH(MUL_DATAWIDTH), .ADD_DATAWIDTH(ADD_DATAWIDTH)) u_mac (
        .a_i(i_act), .b_i(mac_w), .c_i(mac_c), .y_o(mac_y)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_q     <= '0;
            active_q     <= '0;
            weight_q     <= '0;
            act_q        <= '0;
            psum_q       <= '0;
            loaded_q     <= 1'b0;
            w_valid_q    <= 1'b0;
            swap_q       <= 1'b0;
            act_valid_q  <= 1'b0;
            psum_valid_q <= 1'b0;
        end else begin
            w_valid_q <= i_w_valid;
            if (i_w_valid) begin
                shadow_q <= i_weight;
                weight_q <= shadow_q;
            end
            swap_q <= i_swap;
            if (i_swap) begin
                active_q <= shadow_q;
                loaded_q <= 1'b1;
            end
            act_valid_q  <= i_act_valid;
            psum_valid_q <= i_act_valid;
            if (i_act_valid) begin
                act_q  <= i_act;
                psum_q <= mac_y;
            end
        end
    end

    assign o_w_valid    = w_valid_q;
    assign o_weight     = weight_q;
    assign o_swap       = swap_q;
    assign o_act_valid  = act_valid_q;
    assign o_act        = act_q;
    assign o_psum_valid = psum_valid_q;
    assign o_psum       = psum_q;
endmodule

// File: tb/tb_sa_pe_ws.sv
// Self-checking bench for sa_pe_ws: directed scenarios plus a randomized run
// compared cycle by cycle against an integer reference model.

module tb_sa_pe_ws;
    localparam int M = 8;
    localparam int A = 8;

    logic                i_clk = 1'b0;
    logic                i_rst, i_w_valid, i_swap, i_act_valid, i_psum_valid;
    logic signed [M-1:0] i_weight, i_act;
    logic signed [A-1:0] i_psum;
    logic                o_w_valid, o_swap, o_act_valid, o_psum_valid;
    logic signed [M-1:0] o_weight, o_act;
    logic signed [A-1:0] o_psum;
`ifdef SA_PE_SAT_FLAG_EN
    logic                i_sat_clr, o_sat_sticky;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_shadow, m_active, m_loaded, m_oweight, m_wv, m_swap;
    int m_av, m_act, m_pv, m_psum, m_sticky;

    sa_pe_ws #(.MUL_DATAWIDTH(M), .ADD_DATAWIDTH(A)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_w_valid(i_w_valid), .i_weight(i_weight),
        .o_w_valid(o_w_valid), .o_weight(o_weight),
        .i_swap(i_swap), .o_swap(o_swap),
        .i_act_valid(i_act_valid), .i_act(i_act),
        .o_act_valid(o_act_valid), .o_act(o_act),
        .i_psum_valid(i_psum_valid), .i_psum(i_psum),
`ifdef SA_PE_SAT_FLAG_EN
        .i_sat_clr(i_sat_clr), .o_sat_sticky(o_sat_sticky),
`endif
        .o_psum_valid(o_psum_valid), .o_psum(o_psum)
    );

    always #5 i_clk = ~i_clk;

    function automatic int clamp(input int v, input int bits);
        int hi, lo;
        hi = (1 << (bits - 1)) - 1;
        lo = -(1 << (bits - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    task automatic model_step();
        int w, p, prod, ps, s, sat_clr;
        sat_clr = 0;
`ifdef SA_PE_SAT_FLAG_EN
        sat_clr = int'(i_sat_clr);
`endif
        if (i_rst) begin
            m_shadow = 0; m_active = 0; m_loaded = 0; m_oweight = 0; m_wv = 0; m_swap = 0;
            m_av = 0; m_act = 0; m_pv = 0; m_psum = 0; m_sticky = 0;
        end else begin
            w    = m_loaded ? m_active : 0;
            p    = i_psum_valid ? int'(i_psum) : 0;
            prod = int'(i_act) * w;
            ps   = clamp(prod, M);
            s    = clamp(ps + p, A);
            m_av = int'(i_act_valid);
            m_pv = int'(i_act_valid);
            if (i_act_valid) begin
                m_act  = int'(i_act);
                m_psum = s;
            end
            if (i_act_valid && (ps != prod || s != ps + p)) m_sticky = 1;
            else if (sat_clr != 0)                           m_sticky = 0;
            m_swap = int'(i_swap);
            m_wv   = int'(i_w_valid);
            if (i_swap) begin
                m_active = m_shadow;
                m_loaded = 1;
            end
            if (i_w_valid) begin
                m_oweight = m_shadow;
                m_shadow  = int'(i_weight);
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_rst = 0; i_w_valid = 0; i_weight = '0; i_swap = 0;
        i_act_valid = 0; i_act = '0; i_psum_valid = 0; i_psum = '0;
`ifdef SA_PE_SAT_FLAG_EN
        i_sat_clr = 0;
`endif
    endtask

    task automatic load_swap(input int w);
        idle(); i_w_valid = 1; i_weight = M'(w); cyc();
        idle(); i_swap = 1; cyc();
        idle();
    endtask

    task automatic test_reset();
        idle(); i_rst = 1; cyc(); cyc(); idle();
        n_tests++; if (o_psum !== '0 || o_psum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_psum got %0d/%0b want 0/0", o_psum, o_psum_valid); end
        n_tests++; if (o_act !== '0 || o_act_valid !== 1'b0) begin n_fail++; $display("FAIL reset_act got %0d/%0b want 0/0", o_act, o_act_valid); end
        n_tests++; if (o_weight !== '0 || o_w_valid !== 1'b0 || o_swap !== 1'b0) begin n_fail++; $display("FAIL reset_chain got %0d/%0b/%0b want 0/0/0", o_weight, o_w_valid, o_swap); end
`ifdef SA_PE_SAT_FLAG_EN
        n_tests++; if (o_sat_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %0b want 0", o_sat_sticky); end
`endif
    endtask

    task automatic test_load_swap();
        idle(); i_w_valid = 1; i_weight = 8'sd12; cyc();
        n_tests++; if (o_w_valid !== 1'b1 || o_weight !== 8'sd0) begin n_fail++; $display("FAIL load_chain got %0b/%0d want 1/0", o_w_valid, o_weight); end
        idle(); i_swap = 1; cyc();
        n_tests++; if (o_swap !== 1'b1 || o_w_valid !== 1'b0) begin n_fail++; $display("FAIL load_swap_fwd got swap %0b wv %0b want 1/0", o_swap, o_w_valid); end
        idle(); i_act_valid = 1; i_act = 8'sd10; i_psum_valid = 1; i_psum = 8'sd5; cyc();
        n_tests++; if (o_psum !== 8'sd125 || o_psum_valid !== 1'b1) begin n_fail++; $display("FAIL load_mac got %0d/%0b want 125/1", o_psum, o_psum_valid); end
        n_tests++; if (o_act !== 8'sd10 || o_act_valid !== 1'b1 || o_swap !== 1'b0) begin n_fail++; $display("FAIL load_act got %0d/%0b swap %0b want 10/1/0", o_act, o_act_valid, o_swap); end
        idle(); cyc();
        n_tests++; if (o_psum !== 8'sd125 || o_psum_valid !== 1'b0 || o_act !== 8'sd10) begin n_fail++; $display("FAIL load_hold got %0d/%0b act %0d want 125/0/10", o_psum, o_psum_valid, o_act); end
    endtask

    task automatic test_saturation();
        load_swap(16);
        i_act_valid = 1; i_act = 8'sd16; i_psum_valid = 1; i_psum = 8'sd10; cyc();
        n_tests++; if (o_psum !== 8'sd127) begin n_fail++; $display("FAIL sat_pos got %0d want 127", o_psum); end
`ifdef SA_PE_SAT_FLAG_EN
        n_tests++; if (o_sat_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_sticky_set got %0b want 1", o_sat_sticky); end
`endif
        i_act = -8'sd16; i_psum = -8'sd5; cyc();
        n_tests++; if (o_psum !== -8'sd128) begin n_fail++; $display("FAIL sat_neg got %0d want -128", o_psum); end
        idle(); i_act_valid = 1; i_act = 8'sd1; i_psum_valid = 1; i_psum = 8'sd3; cyc();
        n_tests++; if (o_psum !== 8'sd19) begin n_fail++; $display("FAIL sat_none got %0d want 19", o_psum); end
`ifdef SA_PE_SAT_FLAG_EN
        n_tests++; if (o_sat_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_sticky_hold got %0b want 1", o_sat_sticky); end
        idle(); i_sat_clr = 1; cyc(); idle();
        n_tests++; if (o_sat_sticky !== 1'b0) begin n_fail++; $display("FAIL sat_sticky_clr got %0b want 0", o_sat_sticky); end
        i_sat_clr = 1; i_act_valid = 1; i_act = 8'sd100; cyc(); idle();
        n_tests++; if (o_sat_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_sticky_setwins got %0b want 1", o_sat_sticky); end
`endif
    endtask

    task automatic test_psum_invalid();
        load_swap(12);
        i_act_valid = 1; i_act = 8'sd3; i_psum = 8'sd50; i_psum_valid = 0; cyc();
        n_tests++; if (o_psum !== 8'sd36) begin n_fail++; $display("FAIL psum_invalid got %0d want 36", o_psum); end
        idle(); i_rst = 1; cyc(); idle();
        i_act_valid = 1; i_act = 8'sd7; i_psum_valid = 1; i_psum = 8'sd0; cyc();
        n_tests++; if (o_psum !== 8'sd0 || o_psum_valid !== 1'b1) begin n_fail++; $display("FAIL no_weight got %0d/%0b want 0/1", o_psum, o_psum_valid); end
        idle();
    endtask

    task automatic test_same_cycle_swap();
        load_swap(2);
        i_w_valid = 1; i_weight = 8'sd4; cyc(); idle();
        i_swap = 1; i_w_valid = 1; i_weight = 8'sd9; i_act_valid = 1; i_act = 8'sd5; i_psum_valid = 1; i_psum = 8'sd0; cyc();
        n_tests++; if (o_psum !== 8'sd10) begin n_fail++; $display("FAIL swap_old_active got %0d want 10", o_psum); end
        n_tests++; if (o_weight !== 8'sd4) begin n_fail++; $display("FAIL swap_oweight got %0d want 4", o_weight); end
        idle(); i_act_valid = 1; i_act = 8'sd5; i_psum_valid = 1; i_psum = 8'sd0; cyc();
        n_tests++; if (o_psum !== 8'sd20) begin n_fail++; $display("FAIL swap_new_active got %0d want 20", o_psum); end
        idle(); i_w_valid = 1; i_weight = 8'sd0; cyc(); idle();
        n_tests++; if (o_weight !== 8'sd9) begin n_fail++; $display("FAIL swap_shadow got %0d want 9", o_weight); end
    endtask

    task automatic test_reset_midstream();
        load_swap(3);
        i_act_valid = 1; i_act = 8'sd4; cyc();
        i_act = 8'sd6; i_w_valid = 1; i_weight = 8'sd7; i_rst = 1; cyc();
        n_tests++; if (o_psum !== '0 || o_psum_valid !== 1'b0 || o_act !== '0 || o_act_valid !== 1'b0 || o_w_valid !== 1'b0 || o_weight !== '0) begin n_fail++; $display("FAIL rst_mid got psum %0d/%0b act %0d/%0b w %0d/%0b want all 0", o_psum, o_psum_valid, o_act, o_act_valid, o_weight, o_w_valid); end
        idle(); i_act_valid = 1; i_act = 8'sd5; cyc();
        n_tests++; if (o_psum !== 8'sd0 || o_psum_valid !== 1'b1) begin n_fail++; $display("FAIL rst_unloaded got %0d/%0b want 0/1", o_psum, o_psum_valid); end
        idle(); i_swap = 1; cyc(); idle();
        i_act_valid = 1; i_act = 8'sd5; cyc(); idle();
        n_tests++; if (o_psum !== 8'sd0) begin n_fail++; $display("FAIL rst_shadow_cleared got %0d want 0", o_psum); end
    endtask

    task automatic test_back_to_back();
        int acts[3]  = '{1, 2, 3};
        int psums[3] = '{0, 10, 20};
        int exp[3]   = '{2, 14, 26};
        load_swap(2);
        for (int k = 0; k < 3; k++) begin
            i_act_valid = 1; i_act = M'(acts[k]); i_psum_valid = 1; i_psum = A'(psums[k]); cyc();
            n_tests++; if (o_psum !== A'(exp[k]) || o_psum_valid !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] got %0d/%0b want %0d/1", k, o_psum, o_psum_valid, exp[k]); end
        end
        idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            i_rst        = ($urandom_range(0, 39) == 0);
            i_w_valid    = 1'($urandom);
            i_weight     = M'($urandom);
            i_swap       = ($urandom_range(0, 5) == 0);
            i_act_valid  = ($urandom_range(0, 3) != 0);
            i_act        = M'($urandom);
            i_psum_valid = 1'($urandom);
            i_psum       = A'($urandom);
`ifdef SA_PE_SAT_FLAG_EN
            i_sat_clr    = ($urandom_range(0, 7) == 0);
`endif
            cyc();
            n_tests++; if (o_psum !== A'(m_psum) || o_psum_valid !== 1'(m_pv)) begin n_fail++; $display("FAIL rnd_psum[%0d] got %0d/%0b want %0d/%0d", k, o_psum, o_psum_valid, m_psum, m_pv); end
            n_tests++; if (o_act !== M'(m_act) || o_act_valid !== 1'(m_av)) begin n_fail++; $display("FAIL rnd_act[%0d] got %0d/%0b want %0d/%0d", k, o_act, o_act_valid, m_act, m_av); end
            n_tests++; if (o_weight !== M'(m_oweight) || o_w_valid !== 1'(m_wv) || o_swap !== 1'(m_swap)) begin n_fail++; $display("FAIL rnd_chain[%0d] got %0d/%0b/%0b want %0d/%0d/%0d", k, o_weight, o_w_valid, o_swap, m_oweight, m_wv, m_swap); end
`ifdef SA_PE_SAT_FLAG_EN
            n_tests++; if (o_sat_sticky !== 1'(m_sticky)) begin n_fail++; $display("FAIL rnd_sticky[%0d] got %0b want %0d", k, o_sat_sticky, m_sticky); end
`endif
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_swap();
        test_saturation();
        test_psum_invalid();
        test_same_cycle_swap();
        test_reset_midstream();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sa_pe_ws.md
Name: sa_pe_ws

Overview:
- Weight-stationary systolic processing element; the sequential wrapper directly around the combinational saturating MAC (sa_mac_simple).
- Per cycle it computes psum_out = sat(sat(act*weight) + psum_in) against a stationary active weight.
- Activations flow right and partial sums flow down, each through one register stage.
- A double-buffered weight (shadow/active) is loaded through a per-column daisy chain, so the next weight set preloads while the current one computes.

Parameters:
- MUL_DATAWIDTH, 8, width of act/weight operands (signed two's complement).
- ADD_DATAWIDTH, 8, width of psum in/out (signed two's complement).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_w_valid  in  1  weight-chain shift strobe.
- i_weight  in  MUL_DATAWIDTH  weight-chain data from PE above.
- o_w_valid  out  1  registered i_w_valid to PE below.
- o_weight  out  MUL_DATAWIDTH  shadow weight shifted out to PE below.
- i_swap  in  1  commit shadow weight to active weight.
- o_swap  out  1  registered i_swap to PE to the right.
- i_act_valid  in  1  activation valid.
- i_act  in  MUL_DATAWIDTH  activation from PE to the left.
- o_act_valid  out  1  registered i_act_valid.
- o_act  out  MUL_DATAWIDTH  registered i_act.
- i_psum_valid  in  1  psum-in valid (top row ties 0).
- i_psum  in  ADD_DATAWIDTH  partial sum from PE above.
- o_psum_valid  out  1  registered result valid.
- o_psum  out  ADD_DATAWIDTH  registered saturated MAC result.

Behaviour:
- Reset (i_rst=1 at edge): all outputs 0; shadow=0, active=0, active_loaded=0. Reset takes priority over every other input, including mid-load and mid-stream.
- Weight chain:
  - When i_w_valid=1: shadow<=i_weight; o_weight<=old shadow; o_w_valid<=1.
  - Otherwise shadow and o_weight hold; o_w_valid<=0.
  - A column of N PEs is loaded by N consecutive strobes; the first weight pushed lands in the bottom PE.
- Swap:
  - When i_swap=1: active<=shadow; active_loaded<=1; o_swap<=1 the next cycle. This forwards the swap one cycle per column, matching activation skew.
  - If i_swap and i_w_valid are both 1 in the same cycle: active takes the pre-shift shadow value, and shadow takes i_weight.
- Activation path: o_act<=i_act and o_act_valid<=i_act_valid every cycle. Latency 1; o_act holds its last value when invalid.
- Compute, when i_act_valid=1:
  - Operand psum = i_psum if i_psum_valid, else 0.
  - Operand weight = active if active_loaded, else 0.
  - o_psum <= MAC(i_act, weight, psum); o_psum_valid <= 1.
  - A swap in the same cycle does not affect this compute: the old active is used and the new weight applies from the next cycle.
- When i_act_valid=0: o_psum holds; o_psum_valid<=0. If i_psum_valid=1 while i_act_valid=0, the psum is dropped (upstream protocol error, not flagged).
- Arithmetic:
  - Full-width product is saturated to [-2^(M-1), 2^(M-1)-1].
  - It is then added to psum in ADD_DATAWIDTH+1 bits and saturated to [-2^(A-1), 2^(A-1)-1].
  - Behaviour is bit-identical to sa_mac_simple, which is instantiated, not re-coded.
- Throughput: one MAC per cycle; no backpressure.

Optional Feature:
- Macro SA_PE_SAT_FLAG_EN.
- Defined:
  - Adds output port o_sat_sticky (1 bit) and input port i_sat_clr (1 bit).
  - o_sat_sticky sets on any valid compute where either the product or the sum saturated.
  - It clears on i_rst or i_sat_clr; a set in the same cycle as i_sat_clr wins.
  - Reset value 0.
- Undefined: both ports and all detect logic are absent; datapath behaviour is otherwise identical.

Test Plan:
- Reset, then weight load and swap:
  - Pulse i_w_valid with i_weight=12, then i_swap=1.
  - Next cycle o_w_valid=1, o_weight=0; the cycle after the swap o_swap=1.
  - Then i_act=10, i_psum=5, both valids high -> next cycle o_psum=125, o_psum_valid=1, o_act=10.
- Product/sum saturation (weight=16):
  - act=16, psum=10 -> o_psum=127.
  - act=-16, psum=-5 -> o_psum=-128.
  - With SA_PE_SAT_FLAG_EN, o_sat_sticky=1 after the first of these and stays 1 until i_sat_clr.
- Psum invalid, weight=12: act=3, i_psum=50, i_psum_valid=0 -> o_psum=36. No active weight after reset: act=7 -> o_psum=0.
- Same-cycle swap and shift:
  - Setup: shadow=4, active=2.
  - Drive i_swap=1, i_w_valid=1 (i_weight=9) together with i_act=5, psum=0.
  - Result: o_psum=10 (old active); next act=5 gives 20; shadow=9; o_weight=4.
- Reset mid-stream: i_rst=1 while act_valid streams -> next cycle all outputs 0, active_loaded=0; subsequent act=5 gives o_psum=0 until a new load and swap.
- Back-to-back stream, weight=2: acts 1,2,3 with psums 0,10,20 on consecutive cycles -> o_psum 2,14,26 on consecutive cycles, each one cycle after its input, o_psum_valid continuously 1.
